// File: rtl/sr_uart_pkg.sv
// Shared UART TX types: FSM state encoding, idle line level and counter sizing.
// Pure declarations, no logic, no latency or flow-control behaviour.
package sr_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic TX_IDLE_LEVEL = 1'b1;

    function automatic int cnt_width(input int clks);
        return (clks > 2) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/sr_baud_tick.sv
// Bit-period counter: bit_end pulses on the last of every CLKS_PER_BIT cycles.
// Latency 0 from count to bit_end; restart holds the count at 0, no backpressure.
module sr_baud_tick
    import sr_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int CW           = cnt_width(CLKS_PER_BIT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          restart,
    output logic [CW-1:0] count,
    output logic          bit_end
);

    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    assign bit_end = (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            count <= '0;
        end else if (bit_end) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a registered-read FIFO onto a UART TX line, LSB first; start bit 3 cycles after non-empty is seen.
// Pops only in IDLE or the final stop cycle when not empty; FIFO_UART_TX_PARITY_EN adds an even-parity bit.
module fifo_uart_tx
    import sr_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  fifo_read_enable,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CW  = cnt_width(CLKS_PER_BIT);
    localparam int BIW = $clog2(DATA_WIDTH + 1);
    localparam logic [BIW-1:0] LAST_BIT = BIW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]  PRE_END  = CW'(CLKS_PER_BIT - 2);

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic [BIW-1:0]        bit_idx;
    logic                  stop_idx;
    logic [CW-1:0]         count;
    logic                  bit_end;
    logic                  restart;
    logic                  last_stop;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  parity_bit;
`endif

    assign restart   = (state == IDLE) || (state == POP) || (state == LOAD);
    assign shift_nxt = shift_reg >> 1;
    assign last_stop = (STOP_BITS == 1) || stop_idx;

    sr_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .count  (count),
        .bit_end(bit_end)
    );

    // Outputs are registered alongside the state, so each reflects the state it enters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            tx               <= TX_IDLE_LEVEL;
            busy             <= 1'b0;
            fifo_read_enable <= 1'b0;
            tx_done          <= 1'b0;
            shift_reg        <= '0;
            bit_idx          <= '0;
            stop_idx         <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_bit       <= 1'b0;
`endif
        end else begin
            fifo_read_enable <= 1'b0;
            tx_done          <= 1'b0;
            case (state)
                IDLE: begin
                    tx   <= TX_IDLE_LEVEL;
                    busy <= 1'b0;
                    if (!fifo_empty) begin
                        state            <= POP;
                        fifo_read_enable <= 1'b1;
                        busy             <= 1'b1;
                    end
                end
                POP: begin
                    state <= LOAD;
                end
                LOAD: begin
                    shift_reg <= fifo_read_data;
`ifdef FIFO_UART_TX_PARITY_EN
                    parity_bit <= ^fifo_read_data;
`endif
                    bit_idx   <= '0;
                    stop_idx  <= 1'b0;
                    state     <= START;
                    tx        <= 1'b0;
                end
                START: begin
                    if (bit_end) begin
                        state <= DATA;
                        tx    <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_reg <= shift_nxt;
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= parity_bit;
`else
                            state <= STOP;
                            tx    <= TX_IDLE_LEVEL;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shift_nxt[0];
                        end
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        tx    <= TX_IDLE_LEVEL;
                    end
                end
`endif
                STOP: begin
                    // Armed one cycle early so the pulse lands on the final stop cycle.
                    if (last_stop && (count == PRE_END)) begin
                        tx_done <= 1'b1;
                    end
                    if (bit_end) begin
                        if (last_stop) begin
                            if (!fifo_empty) begin
                                state            <= POP;
                                fifo_read_enable <= 1'b1;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= TX_IDLE_LEVEL;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one STOP_BITS=1 and one STOP_BITS=2 instance, each fed by a small FIFO model.
module tb_fifo_uart_tx;

`ifdef FIFO_UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       fifo_empty1, fifo_read_enable1, tx1, busy1, tx_done1;
    logic [7:0] fifo_read_data1 = 8'h00;
    logic       fifo_empty2, fifo_read_enable2, tx2, busy2, tx_done2;
    logic [7:0] fifo_read_data2 = 8'h00;

    logic [7:0] mem1 [0:15];
    logic [7:0] mem2 [0:15];
    int         wr1 = 0, rd1 = 0, wr2 = 0, rd2 = 0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign fifo_empty1 = (wr1 == rd1);
    assign fifo_empty2 = (wr2 == rd2);

    always @(posedge clk) begin
        if (fifo_read_enable1) begin
            fifo_read_data1 <= mem1[rd1[3:0]];
            rd1 <= rd1 + 1;
        end
    end

    always @(posedge clk) begin
        if (fifo_read_enable2) begin
            fifo_read_data2 <= mem2[rd2[3:0]];
            rd2 <= rd2 + 1;
        end
    end

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut1 (
        .clk             (clk),
        .reset           (reset),
        .fifo_empty      (fifo_empty1),
        .fifo_read_data  (fifo_read_data1),
        .fifo_read_enable(fifo_read_enable1),
        .tx              (tx1),
        .busy            (busy1),
        .tx_done         (tx_done1)
    );

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
        .clk             (clk),
        .reset           (reset),
        .fifo_empty      (fifo_empty2),
        .fifo_read_data  (fifo_read_data2),
        .fifo_read_enable(fifo_read_enable2),
        .tx              (tx2),
        .busy            (busy2),
        .tx_done         (tx_done2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [7:0] b);
        mem1[wr1[3:0]] = b;
        wr1 = wr1 + 1;
    endtask

    task automatic push2(input logic [7:0] b);
        mem2[wr2[3:0]] = b;
        wr2 = wr2 + 1;
    endtask

    // Expected {fifo_read_enable, busy, tx, tx_done} k cycles after the IDLE cycle that saw non-empty.
    function automatic logic [3:0] exp_vec(input int k, input int nframes, input logic [7:0] b0,
                                           input logic [7:0] b1, input int stop_bits, input bit par);
        int         len, period, idx, kk, f, bi;
        logic [7:0] b;
        logic       t;
        len    = (9 + stop_bits + int'(par)) * 4;
        period = len + 2;
        if (k < 1 || k > nframes * period) return 4'b0010;
        idx = (k - 1) / period;
        kk  = (k - 1) % period + 1;
        b   = (idx == 0) ? b0 : b1;
        if (kk <= 2) begin
            t = 1'b1;
        end else begin
            f  = kk - 3;
            bi = f / 4;
            if (bi == 0)               t = 1'b0;
            else if (bi <= 8)          t = b[bi-1];
            else if (par && bi == 9)   t = ^b;
            else                       t = 1'b1;
        end
        return {(kk == 1), 1'b1, t, (kk == period)};
    endfunction

    task automatic test_reset();
        logic [3:0] got;
        reset = 1'b1;
        tick();
        tick();
        got = {fifo_read_enable1, busy1, tx1, tx_done1};
        checks++;
        if (got !== 4'b0010) begin
            failures++;
            $display("FAIL reset_state1 got=%b expected=0010", got);
        end
        got = {fifo_read_enable2, busy2, tx2, tx_done2};
        checks++;
        if (got !== 4'b0010) begin
            failures++;
            $display("FAIL reset_state2 got=%b expected=0010", got);
        end
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            got = {fifo_read_enable1, busy1, tx1, tx_done1};
            checks++;
            if (got !== 4'b0010) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d got=%b expected=0010", k, got);
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] got, exp;
        int         rd0;
        rd0 = rd1;
        push1(8'hA5);
        for (int k = 1; k <= 48; k++) begin
            tick();
            got = {fifo_read_enable1, busy1, tx1, tx_done1};
            exp = exp_vec(k, 1, 8'hA5, 8'h00, 1, PAR);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL single_a5 k=%0d got=%b expected=%b", k, got, exp);
            end
        end
        checks++;
        if (rd1 - rd0 !== 1) begin
            failures++;
            $display("FAIL single_strobes got=%0d expected=1", rd1 - rd0);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] got, exp;
        int         rd0;
        rd0 = rd1;
        push1(8'h00);
        push1(8'hFF);
        for (int k = 1; k <= 94; k++) begin
            tick();
            got = {fifo_read_enable1, busy1, tx1, tx_done1};
            exp = exp_vec(k, 2, 8'h00, 8'hFF, 1, PAR);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL back_to_back k=%0d got=%b expected=%b", k, got, exp);
            end
        end
        checks++;
        if (rd1 - rd0 !== 2) begin
            failures++;
            $display("FAIL b2b_strobes got=%0d expected=2", rd1 - rd0);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] got, exp;
        int         rd0;
        rd0 = rd1;
        push1(8'h3C);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 5) push1(8'h81);
            got = {fifo_read_enable1, busy1, tx1, tx_done1};
            exp = exp_vec(k, 1, 8'h3C, 8'h00, 1, PAR);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL pre_reset k=%0d got=%b expected=%b", k, got, exp);
            end
        end
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            got = {fifo_read_enable1, busy1, tx1, tx_done1};
            checks++;
            if (got !== 4'b0010) begin
                failures++;
                $display("FAIL mid_reset cycle=%0d got=%b expected=0010", k, got);
            end
        end
        reset = 1'b0;
        for (int k = 1; k <= 48; k++) begin
            tick();
            got = {fifo_read_enable1, busy1, tx1, tx_done1};
            exp = exp_vec(k, 1, 8'h81, 8'h00, 1, PAR);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL after_reset k=%0d got=%b expected=%b", k, got, exp);
            end
        end
        checks++;
        if (rd1 - rd0 !== 2) begin
            failures++;
            $display("FAIL reset_strobes got=%0d expected=2", rd1 - rd0);
        end
    endtask

`ifdef FIFO_UART_TX_PARITY_EN
    task automatic test_parity();
        logic [3:0] got, exp;
        int         rd0;
        rd0 = rd1;
        push1(8'h07);
        push1(8'h03);
        for (int k = 1; k <= 96; k++) begin
            tick();
            got = {fifo_read_enable1, busy1, tx1, tx_done1};
            exp = exp_vec(k, 2, 8'h07, 8'h03, 1, 1'b1);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL parity k=%0d got=%b expected=%b", k, got, exp);
            end
        end
        checks++;
        if (rd1 - rd0 !== 2) begin
            failures++;
            $display("FAIL parity_strobes got=%0d expected=2", rd1 - rd0);
        end
    endtask
`endif

    task automatic test_stop2();
        logic [3:0] got, exp;
        int         rd0;
        rd0 = rd2;
        push2(8'h55);
        push2(8'hAA);
        for (int k = 1; k <= 104; k++) begin
            tick();
            got = {fifo_read_enable2, busy2, tx2, tx_done2};
            exp = exp_vec(k, 2, 8'h55, 8'hAA, 2, PAR);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL stop2 k=%0d got=%b expected=%b", k, got, exp);
            end
        end
        checks++;
        if (rd2 - rd0 !== 2) begin
            failures++;
            $display("FAIL stop2_strobes got=%0d expected=2", rd2 - rd0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
`ifdef FIFO_UART_TX_PARITY_EN
        test_parity();
`endif
        test_stop2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
